// File: rtl/pwm_sample_sched_if.sv
// Sample/config bus between the effects pipeline and the PWM sample scheduler.
//   s_data/s_valid/s_ready : 8-bit sample stream with valid/ready handshake
//   cfg_we/cfg_addr/cfg_wdata : register write port
//                               (0=time_add, 1=cycle_adder, 2=freq_div, 3=sample_period)
// master = producer (pipeline / bench), slave = pwm_sample_sched.
interface pwm_sample_sched_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;

  modport master (
    output s_data, s_valid, cfg_we, cfg_addr, cfg_wdata,
    input  s_ready
  );

  modport slave (
    input  s_data, s_valid, cfg_we, cfg_addr, cfg_wdata,
    output s_ready
  );
endinterface

// File: rtl/pwm_sample_sched.sv
// Sample-rate scheduler and configuration owner for the 8-bit PWM audio stage.
// Buffers incoming samples in a FIFO, hands one sample per sample period to
// the PWM with a one-cycle pwm_start strobe, and keeps the PWM timing config
// in shadow registers that only become active on sample boundaries.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable          : playback enable
//   bus (slave)     : sample stream + config write port
//   pwm_data/pwm_start/pwm_cs : sample, update strobe and chip select to PWM
//   time_add/cycle_adder/freq_div : active PWM configuration
//   fifo_level      : FIFO occupancy
//   underruns       : saturating count of ticks that found the FIFO empty
//   state           : 0=IDLE, 1=PRIME, 2=RUN
module pwm_sample_sched #(
  parameter int DEPTH        = 16,
  parameter int PRIME_LEVEL  = 8,
  parameter int UNDERRUN_MAX = 4,
  parameter int PERIOD_RST   = 12000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  pwm_sample_sched_if.slave        bus,
  output logic [7:0]               pwm_data,
  output logic                     pwm_start,
  output logic                     pwm_cs,
  output logic [31:0]              time_add,
  output logic [31:0]              cycle_adder,
  output logic [31:0]              freq_div,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               underruns,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = $clog2(UNDERRUN_MAX + 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
  localparam logic [EW-1:0] EMPTY_MAX = EW'(UNDERRUN_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [31:0]     count_reg, period_reg, period_eff;
  logic [31:0]     time_add_sh_reg, cycle_adder_sh_reg, freq_div_sh_reg;
  logic [31:0]     time_add_reg, cycle_adder_reg, freq_div_reg;
  logic [7:0]      pwm_data_reg, underruns_reg;
  logic            pwm_start_reg;
  logic [EW-1:0]   empty_cnt_reg;
  logic            tick, act, push, pop, fifo_empty;

  assign bus.s_ready = (level_reg != FULL_LVL);
  assign push        = bus.s_valid && bus.s_ready;
  assign fifo_empty  = (level_reg == '0);
  assign period_eff  = (period_reg == 32'd0) ? 32'd1 : period_reg;
  // ">=" so that shrinking the period below the current count still ticks
  // immediately instead of waiting for the 32-bit counter to wrap.
  assign tick        = (state_reg != ST_IDLE) && (count_reg >= period_eff - 32'd1);
  // A tick that would strobe right after the previous strobe is skipped,
  // so with a period of 1 the PWM is updated every second cycle.
  assign act         = tick && enable && (state_reg == ST_RUN) && !pwm_start_reg;
  assign pop         = act && !fifo_empty;

  // The return to PRIME is taken one cycle after the final empty tick so the
  // re-send strobe of that tick still lands while in RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_PRIME;
      ST_PRIME: if (tick && (level_reg >= PRIME_LVL)) state_next = ST_RUN;
      ST_RUN:   if (empty_cnt_reg == EMPTY_MAX) state_next = ST_PRIME;
      default:  state_next = ST_IDLE;
    endcase
    if (!enable) state_next = ST_IDLE;
  end

  // Sample storage: no reset, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr_reg] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      level_reg          <= '0;
      count_reg          <= '0;
      period_reg         <= 32'(PERIOD_RST);
      time_add_sh_reg    <= 32'd0;
      cycle_adder_sh_reg <= 32'd1;
      freq_div_sh_reg    <= 32'(PERIOD_RST / 2);
      time_add_reg       <= 32'd0;
      cycle_adder_reg    <= 32'd1;
      freq_div_reg       <= 32'(PERIOD_RST / 2);
      pwm_data_reg       <= 8'h80;
      pwm_start_reg      <= 1'b0;
      underruns_reg      <= 8'd0;
      empty_cnt_reg      <= '0;
    end else begin
      state_reg <= state_next;

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + LW'(push) - LW'(pop);

      if ((state_reg == ST_IDLE) || !enable || tick) count_reg <= 32'd0;
      else                                           count_reg <= count_reg + 32'd1;

      pwm_start_reg <= act;
      if (!enable)  pwm_data_reg <= 8'h80;
      else if (pop) pwm_data_reg <= mem[rd_ptr_reg];

      if (act) begin
        if (fifo_empty) begin
          empty_cnt_reg <= empty_cnt_reg + 1'b1;
          if (underruns_reg != 8'hFF) underruns_reg <= underruns_reg + 8'd1;
        end else begin
          empty_cnt_reg <= '0;
        end
      end else if (state_reg != ST_RUN) begin
        empty_cnt_reg <= '0;
      end

      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          2'd0:    time_add_sh_reg    <= bus.cfg_wdata;
          2'd1:    cycle_adder_sh_reg <= bus.cfg_wdata;
          2'd2:    freq_div_sh_reg    <= bus.cfg_wdata;
          default: period_reg         <= bus.cfg_wdata;
        endcase
      end

      // Active config follows the shadows at each strobe, and freely in IDLE.
      if ((state_reg == ST_IDLE) || act) begin
        time_add_reg    <= time_add_sh_reg;
        cycle_adder_reg <= cycle_adder_sh_reg;
        freq_div_reg    <= freq_div_sh_reg;
      end
    end
  end

  assign pwm_data    = pwm_data_reg;
  assign pwm_start   = pwm_start_reg;
  assign pwm_cs      = (state_reg != ST_IDLE);
  assign time_add    = time_add_reg;
  assign cycle_adder = cycle_adder_reg;
  assign freq_div    = freq_div_reg;
  assign fifo_level  = level_reg;
  assign underruns   = underruns_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Directed bench for pwm_sample_sched. Main instance uses default parameters;
// a second instance (PRIME_LEVEL=1, UNDERRUN_MAX=512, PERIOD_RST=2) stays in
// RUN long enough to exercise underrun saturation.
module tb_pwm_sample_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic enable2 = 1'b0;
  always #5 clk = ~clk;

  pwm_sample_sched_if bus ();
  pwm_sample_sched_if bus2 ();

  logic [7:0]  pwm_data, underruns, pwm_data2, underruns2;
  logic        pwm_start, pwm_cs, pwm_start2, pwm_cs2;
  logic [31:0] time_add, cycle_adder, freq_div, time_add2, cycle_adder2, freq_div2;
  logic [4:0]  fifo_level;
  logic [2:0]  fifo_level2;
  logic [1:0]  state, state2;

  pwm_sample_sched dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .pwm_data(pwm_data), .pwm_start(pwm_start), .pwm_cs(pwm_cs),
    .time_add(time_add), .cycle_adder(cycle_adder), .freq_div(freq_div),
    .fifo_level(fifo_level), .underruns(underruns), .state(state)
  );

  pwm_sample_sched #(.DEPTH(4), .PRIME_LEVEL(1), .UNDERRUN_MAX(512), .PERIOD_RST(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .bus(bus2),
    .pwm_data(pwm_data2), .pwm_start(pwm_start2), .pwm_cs(pwm_cs2),
    .time_add(time_add2), .cycle_adder(cycle_adder2), .freq_div(freq_div2),
    .fifo_level(fifo_level2), .underruns(underruns2), .state(state2)
  );

  int checks = 0;
  int passed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    bus.s_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.s_data = first + 8'(i);
      step();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_pulse(input bit sel, input int bound, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      waited++;
      if ((sel ? pwm_start2 : pwm_start) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_run(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (state === 2'd2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else passed++;
    checks++; if (fifo_level !== 5'd0) $display("FAIL rst_level: got %0d want 0", fifo_level); else passed++;
    checks++; if (bus.s_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.s_ready); else passed++;
    checks++; if (pwm_data !== 8'h80) $display("FAIL rst_data: got %h want 80", pwm_data); else passed++;
    checks++; if (pwm_start !== 1'b0) $display("FAIL rst_start: got %b want 0", pwm_start); else passed++;
    checks++; if (pwm_cs !== 1'b0) $display("FAIL rst_cs: got %b want 0", pwm_cs); else passed++;
    checks++; if (underruns !== 8'd0) $display("FAIL rst_underruns: got %0d want 0", underruns); else passed++;
    checks++; if (time_add !== 32'd0) $display("FAIL rst_time_add: got %0d want 0", time_add); else passed++;
    checks++; if (cycle_adder !== 32'd1) $display("FAIL rst_cycle_adder: got %0d want 1", cycle_adder); else passed++;
    checks++; if (freq_div !== 32'd6000) $display("FAIL rst_freq_div: got %0d want 6000", freq_div); else passed++;
    $display("reset: state=%0d level=%0d data=%h freq_div=%0d", state, fifo_level, pwm_data, freq_div);
  endtask

  task automatic test_prime_empty();
    int starts = 0;
    int bad_state = 0;
    cfg_write(2'd3, 32'd10);
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (pwm_start === 1'b1) starts++;
      if (state !== 2'd1) bad_state++;
    end
    checks++; if (starts !== 0) $display("FAIL prime_no_start: got %0d pulses want 0", starts); else passed++;
    checks++; if (bad_state !== 0) $display("FAIL prime_state: got %0d non-PRIME cycles want 0", bad_state); else passed++;
    checks++; if (pwm_cs !== 1'b1) $display("FAIL prime_cs: got %b want 1", pwm_cs); else passed++;
    checks++; if (pwm_data !== 8'h80) $display("FAIL prime_data: got %h want 80", pwm_data); else passed++;
    enable = 1'b0;
    step();
    checks++; if (state !== 2'd0) $display("FAIL prime_to_idle: got %0d want 0", state); else passed++;
    $display("prime_empty: pulses=%0d state=%0d", starts, state);
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    do_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.s_data = 8'(i);
      if (bus.s_ready === 1'b1) acc++;
      step();
    end
    bus.s_valid = 1'b0;
    checks++; if (acc !== 16) $display("FAIL full_accepted: got %0d want 16", acc); else passed++;
    checks++; if (fifo_level !== 5'd16) $display("FAIL full_level: got %0d want 16", fifo_level); else passed++;
    checks++; if (bus.s_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.s_ready); else passed++;
    $display("fifo_full: accepted=%0d level=%0d", acc, fifo_level);
  endtask

  task automatic test_playback();
    bit ok;
    int waited;
    do_reset();
    cfg_write(2'd3, 32'd10);
    push_seq(8'h10, 8);
    checks++; if (fifo_level !== 5'd8) $display("FAIL play_level0: got %0d want 8", fifo_level); else passed++;
    enable = 1'b1;
    wait_run(30, ok);
    checks++; if (!ok) $display("FAIL play_enter_run: got state %0d want 2", state); else passed++;
    for (int k = 0; k < 8; k++) begin
      wait_pulse(1'b0, 12, ok, waited);
      $display("pulse %0d: data=%h level=%0d gap=%0d", k, pwm_data, fifo_level, waited);
      checks++; if (!ok) $display("FAIL play_pulse%0d: got no pulse want pulse", k); else passed++;
      checks++; if (pwm_data !== 8'h10 + 8'(k)) $display("FAIL play_data%0d: got %h want %h", k, pwm_data, 8'h10 + 8'(k)); else passed++;
      checks++; if (fifo_level !== 5'(7 - k)) $display("FAIL play_level%0d: got %0d want %0d", k, fifo_level, 7 - k); else passed++;
      if (k > 0) begin
        checks++; if (waited !== 10) $display("FAIL play_gap%0d: got %0d want 10", k, waited); else passed++;
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int waited;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(1'b0, 12, ok, waited);
      $display("underrun pulse %0d: data=%h underruns=%0d state=%0d", k, pwm_data, underruns, state);
      checks++; if (!ok || waited !== 10) $display("FAIL ur_gap%0d: got %0d want 10", k, waited); else passed++;
      checks++; if (pwm_data !== 8'h17) $display("FAIL ur_data%0d: got %h want 17", k, pwm_data); else passed++;
      checks++; if (underruns !== 8'(k + 1)) $display("FAIL ur_count%0d: got %0d want %0d", k, underruns, k + 1); else passed++;
      checks++; if (state !== 2'd2) $display("FAIL ur_state%0d: got %0d want 2", k, state); else passed++;
    end
    step();
    checks++; if (state !== 2'd1) $display("FAIL ur_to_prime: got %0d want 1", state); else passed++;
  endtask

  task automatic test_shadow();
    bit ok;
    int waited;
    int bad = 0;
    int bad_pat = 0;
    int bad_data = 0;
    push_seq(8'h20, 8);
    wait_run(30, ok);
    checks++; if (!ok) $display("FAIL sh_enter_run: got state %0d want 2", state); else passed++;
    wait_pulse(1'b0, 12, ok, waited);
    checks++; if (!ok || pwm_data !== 8'h20) $display("FAIL sh_first: got %h want 20", pwm_data); else passed++;
    step(); step(); step();
    cfg_write(2'd2, 32'd6250);
    checks++; if (freq_div !== 32'd6000) $display("FAIL sh_hold: got %0d want 6000", freq_div); else passed++;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pwm_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (freq_div !== 32'd6000) bad++;
    end
    checks++; if (!ok) $display("FAIL sh_pulse: got no pulse want pulse"); else passed++;
    checks++; if (bad !== 0) $display("FAIL sh_early: got %0d early cycles want 0", bad); else passed++;
    checks++; if (freq_div !== 32'd6250) $display("FAIL sh_apply: got %0d want 6250", freq_div); else passed++;
    checks++; if (pwm_data !== 8'h21) $display("FAIL sh_data: got %h want 21", pwm_data); else passed++;
    $display("shadow: freq_div=%0d at pulse", freq_div);
    cfg_write(2'd3, 32'd0);
    wait_pulse(1'b0, 4, ok, waited);
    checks++; if (!ok || pwm_data !== 8'h22) $display("FAIL p0_first: got %h want 22", pwm_data); else passed++;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pwm_start !== ((i % 2) == 0)) bad_pat++;
      if ((i % 2) == 0 && pwm_data !== 8'h22 + 8'(i / 2)) bad_data++;
    end
    checks++; if (bad_pat !== 0) $display("FAIL p0_pattern: got %0d bad cycles want 0", bad_pat); else passed++;
    checks++; if (bad_data !== 0) $display("FAIL p0_data: got %0d bad samples want 0", bad_data); else passed++;
    checks++; if (fifo_level !== 5'd0) $display("FAIL p0_level: got %0d want 0", fifo_level); else passed++;
    $display("period0: last data=%h", pwm_data);
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    step();
    checks++; if (state !== 2'd0) $display("FAIL off_state: got %0d want 0", state); else passed++;
    checks++; if (pwm_data !== 8'h80) $display("FAIL off_data: got %h want 80", pwm_data); else passed++;
    checks++; if (pwm_start !== 1'b0) $display("FAIL off_start: got %b want 0", pwm_start); else passed++;
    checks++; if (underruns !== 8'd4) $display("FAIL off_underruns: got %0d want 4", underruns); else passed++;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int waited;
    cfg_write(2'd3, 32'd10);
    push_seq(8'h30, 8);
    enable = 1'b1;
    wait_run(30, ok);
    checks++; if (!ok) $display("FAIL mr_enter_run: got state %0d want 2", state); else passed++;
    for (int k = 0; k < 3; k++) wait_pulse(1'b0, 12, ok, waited);
    checks++; if (fifo_level !== 5'd5 || pwm_data !== 8'h32) $display("FAIL mr_pre: got level %0d data %h want 5 32", fifo_level, pwm_data); else passed++;
    checks++; if (freq_div !== 32'd6250) $display("FAIL mr_pre_freq: got %0d want 6250", freq_div); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    enable = 1'b0;
    checks++; if (state !== 2'd0) $display("FAIL mr_state: got %0d want 0", state); else passed++;
    checks++; if (fifo_level !== 5'd0) $display("FAIL mr_level: got %0d want 0", fifo_level); else passed++;
    checks++; if (pwm_data !== 8'h80) $display("FAIL mr_data: got %h want 80", pwm_data); else passed++;
    checks++; if (freq_div !== 32'd6000) $display("FAIL mr_freq: got %0d want 6000", freq_div); else passed++;
    checks++; if (underruns !== 8'd0) $display("FAIL mr_underruns: got %0d want 0", underruns); else passed++;
    checks++; if (bus.s_ready !== 1'b1) $display("FAIL mr_ready: got %b want 1", bus.s_ready); else passed++;
    $display("reset_mid_run: state=%0d level=%0d", state, fifo_level);
  endtask

  task automatic test_saturate();
    bit ok;
    int waited;
    int timeouts = 0;
    logic [7:0] u254 = 8'd0;
    do_reset();
    bus2.s_valid = 1'b1;
    bus2.s_data = 8'hAB;
    step();
    bus2.s_valid = 1'b0;
    enable2 = 1'b1;
    wait_pulse(1'b1, 20, ok, waited);
    checks++; if (!ok || pwm_data2 !== 8'hAB) $display("FAIL sat_first: got %h want ab", pwm_data2); else passed++;
    for (int n = 1; n <= 300; n++) begin
      wait_pulse(1'b1, 4, ok, waited);
      if (!ok) timeouts++;
      if (n == 254) u254 = underruns2;
    end
    checks++; if (timeouts !== 0) $display("FAIL sat_timeouts: got %0d want 0", timeouts); else passed++;
    checks++; if (u254 !== 8'd254) $display("FAIL sat_254: got %0d want 254", u254); else passed++;
    checks++; if (underruns2 !== 8'd255) $display("FAIL sat_255: got %0d want 255", underruns2); else passed++;
    checks++; if (state2 !== 2'd2 || pwm_data2 !== 8'hAB) $display("FAIL sat_hold: got state %0d data %h want 2 ab", state2, pwm_data2); else passed++;
    $display("saturate: underruns=%0d", underruns2);
    enable2 = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = 8'h00;
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'd0;
    bus2.s_valid = 1'b0; bus2.s_data = 8'h00;
    bus2.cfg_we = 1'b0; bus2.cfg_addr = 2'd0; bus2.cfg_wdata = 32'd0;
    test_reset();
    test_prime_empty();
    test_fifo_full();
    test_playback();
    test_underrun();
    test_shadow();
    test_enable_off();
    test_reset_mid_run();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
